// File: rtl/mfu_op_decoder.sv
// Identifies the 3-bit logic-unit function select from serial (a, b, y) samples.
// Optional early resolution on a single remaining candidate: define MFU_DEC_EARLY_EN.
module mfu_op_decoder #(
    parameter int unsigned MAX_SAMPLES = 16,
    parameter int unsigned CNT_W       = $clog2(MAX_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_a,
    input  logic             s_b,
    input  logic             s_y,
    output logic             busy,
    output logic             done,
    output logic [2:0]       op,
    output logic             op_ok,
    output logic [1:0]       err,
    output logic [7:0]       cand,
    output logic [CNT_W-1:0] cnt
);

    // Truth table per opcode, bit index {a,b}
    localparam logic [3:0] TRUTH [8] = '{4'h8, 4'hE, 4'h3, 4'h7, 4'h1, 4'h6, 4'h9, 4'h0};

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e           state_q, state_d;
    logic [7:0]       cand_q;
    logic [3:0]       seen_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic             op_ok_q;
    logic [1:0]       err_q;

    logic [1:0]       idx;
    logic             hs;
    logic [7:0]       match;
    logic [7:0]       cand_n;
    logic [3:0]       seen_n;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       op_n;
    logic             exit_conflict;
    logic             exit_one;
    logic             exit_resolved;
    logic             exit_limit;
    logic             finish;

    assign idx = {s_a, s_b};
    assign hs  = (state_q == StCollect) && s_valid;

    always_comb begin
        match = '0;
        op_n  = '0;
        for (int k = 0; k < 8; k++) begin
            match[k] = (TRUTH[k][idx] == s_y);
        end
        cand_n = cand_q & match;
        seen_n = seen_q | (4'b0001 << idx);
        cnt_n  = cnt_q + CNT_W'(1);
        // Only meaningful when a single candidate survives
        for (int k = 0; k < 8; k++) begin
            if (cand_n[k]) begin
                op_n = 3'(k);
            end
        end
    end

`ifdef MFU_DEC_EARLY_EN
    // Zero is excluded by the higher-priority conflict exit
    assign exit_one = ((cand_n & (cand_n - 8'd1)) == 8'd0);
`else
    assign exit_one = 1'b0;
`endif

    assign exit_conflict = (cand_n == 8'd0);
    assign exit_resolved = !exit_conflict && (exit_one || (seen_n == 4'hF));
    assign exit_limit    = (cnt_n == CNT_W'(MAX_SAMPLES));
    assign finish        = exit_conflict || exit_resolved || exit_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCollect;
            StCollect: if (hs && finish) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        s_ready = (state_q == StCollect);
        busy    = (state_q == StCollect) || (state_q == StDone);
        done    = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q  <= 8'hFF;
            seen_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            op_ok_q <= 1'b0;
            err_q   <= 2'b00;
        end else if ((state_q == StIdle) && start) begin
            cand_q  <= 8'hFF;
            seen_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            op_ok_q <= 1'b0;
            err_q   <= 2'b00;
        end else if (hs) begin
            cand_q <= cand_n;
            seen_q <= seen_n;
            cnt_q  <= cnt_n;
            if (exit_conflict) begin
                err_q <= 2'b01;
            end else if (exit_resolved) begin
                op_ok_q <= 1'b1;
                op_q    <= op_n;
            end else if (exit_limit) begin
                err_q <= 2'b10;
            end
        end
    end

    assign op    = op_q;
    assign op_ok = op_ok_q;
    assign err   = err_q;
    assign cand  = cand_q;
    assign cnt   = cnt_q;

endmodule

// File: tb/tb_mfu_op_decoder.sv
// Randomized and directed bench for mfu_op_decoder against a set-elimination model.
// Instance 0 uses the default sample limit, instance 1 uses a limit of 4.
module tb_mfu_op_decoder;

`ifdef MFU_DEC_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] start, s_valid, s_a, s_b, s_y;
    logic [1:0] s_ready, busy, done, op_ok;
    logic [2:0] op_w   [2];
    logic [1:0] err_w  [2];
    logic [7:0] cand_w [2];
    logic [4:0] cnt0;
    logic [2:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    bit [7:0] m_cand;
    bit [3:0] m_seen;
    int       m_cnt;
    bit       m_done;
    bit       m_ok;
    int       m_err;
    int       m_op;

    mfu_op_decoder dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_a(s_a[0]), .s_b(s_b[0]), .s_y(s_y[0]), .busy(busy[0]), .done(done[0]),
        .op(op_w[0]), .op_ok(op_ok[0]), .err(err_w[0]), .cand(cand_w[0]), .cnt(cnt0)
    );

    mfu_op_decoder #(.MAX_SAMPLES(4)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_a(s_a[1]), .s_b(s_b[1]), .s_y(s_y[1]), .busy(busy[1]), .done(done[1]),
        .op(op_w[1]), .op_ok(op_ok[1]), .err(err_w[1]), .cand(cand_w[1]), .cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cnt_of(input int u);
        return (u == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    // Behavioural definition of each function select
    function automatic bit ref_y(input int code, input bit a, input bit b);
        case (code)
            0:       return a & b;
            1:       return a | b;
            2:       return !a;
            3:       return !(a & b);
            4:       return !(a | b);
            5:       return a ^ b;
            6:       return !(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_reset(input int u);
        check("rst_ready", s_ready[u], 0);
        check("rst_busy", busy[u], 0);
        check("rst_done", done[u], 0);
        check("rst_op", op_w[u], 0);
        check("rst_op_ok", op_ok[u], 0);
        check("rst_err", err_w[u], 0);
        check("rst_cand", cand_w[u], 8'hFF);
        check("rst_cnt", cnt_of(u), 0);
    endtask

    // Called at a negedge with the instance idle
    task automatic do_start(input int u);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        m_cand = 8'hFF;
        m_seen = '0;
        m_cnt  = 0;
        m_done = 1'b0;
        m_ok   = 1'b0;
        m_err  = 0;
        m_op   = 0;
        check("start_busy", busy[u], 1);
        check("start_cnt", cnt_of(u), 0);
        check("start_cand", cand_w[u], 8'hFF);
    endtask

    task automatic idle(input int u, input int cycles, input bit pulse);
        for (int i = 0; i < cycles; i++) begin
            s_valid[u] = 1'b0;
            start[u]   = pulse;
            @(negedge clk);
            start[u] = 1'b0;
            check("gap_cnt", cnt_of(u), m_cnt);
            check("gap_cand", cand_w[u], m_cand);
            check("gap_done", done[u], 0);
            check("gap_busy", busy[u], 1);
        end
    endtask

    task automatic send(input int u, input int maxs, input bit [2:0] s);
        bit a, b, y;
        int nc, hi;
        a = s[2];
        b = s[1];
        y = s[0];
        check("ready", s_ready[u], 1);
        s_valid[u] = 1'b1;
        s_a[u] = a;
        s_b[u] = b;
        s_y[u] = y;
        @(negedge clk);
        s_valid[u] = 1'b0;
        s_a[u] = 1'($urandom);
        s_b[u] = 1'($urandom);
        s_y[u] = 1'($urandom);
        for (int k = 0; k < 8; k++) begin
            if (ref_y(k, a, b) != y) m_cand[k] = 1'b0;
        end
        m_seen[{a, b}] = 1'b1;
        m_cnt++;
        nc = 0;
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            if (m_cand[k]) begin
                nc++;
                hi = k;
            end
        end
        m_done = 1'b1;
        if (nc == 0) begin
            m_err = 1;
        end else if ((EARLY && nc == 1) || m_seen == 4'hF) begin
            m_ok = 1'b1;
            m_op = hi;
        end else if (m_cnt == maxs) begin
            m_err = 2;
        end else begin
            m_done = 1'b0;
        end
        check("cand", cand_w[u], m_cand);
        check("cnt", cnt_of(u), m_cnt);
        check("done", done[u], m_done);
        check("busy", busy[u], 1);
        check("ready_after", s_ready[u], !m_done);
        check("op_ok", op_ok[u], m_ok);
        check("err", err_w[u], m_err);
        check("op", op_w[u], m_op);
        if (m_done) begin
            // start during the done cycle must be ignored
            start[u] = 1'($urandom_range(0, 1));
            @(negedge clk);
            start[u] = 1'b0;
            check("post_done", done[u], 0);
            check("post_busy", busy[u], 0);
            check("hold_op", op_w[u], m_op);
            check("hold_op_ok", op_ok[u], m_ok);
            check("hold_err", err_w[u], m_err);
            check("hold_cand", cand_w[u], m_cand);
            check("hold_cnt", cnt_of(u), m_cnt);
        end
    endtask

    // Samples packed {a,b,y}, first sample in the most significant used slot
    task automatic run_list(input int u, input int maxs, input int n, input logic [47:0] pk);
        for (int i = 0; i < n; i++) begin
            if (!m_done) send(u, maxs, pk[3*(n-1-i) +: 3]);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = '0;
        s_valid = '0;
        s_a     = '0;
        s_b     = '0;
        s_y     = '0;
        repeat (2) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(negedge clk);

        // NOT-a fully resolved
        do_start(0);
        run_list(0, 16, 4, 48'({3'b001, 3'b110, 3'b011, 3'b100}));
        check("t1_op", op_w[0], 3'b010);
        check("t1_op_ok", op_ok[0], 1);
        check("t1_err", err_w[0], 0);
        check("t1_cand", cand_w[0], 8'h04);
        check("t1_cnt", cnt_of(0), 4);

        // XOR: early exit after 3 samples when enabled, else a 4th is needed
        do_start(0);
        run_list(0, 16, 3, 48'({3'b000, 3'b110, 3'b011}));
        if (!m_done) send(0, 16, 3'b101);
        check("t2_op", op_w[0], 3'b101);
        check("t2_op_ok", op_ok[0], 1);
        check("t2_cnt", cnt_of(0), EARLY ? 3 : 4);

        // Contradicting repeat
        do_start(0);
        run_list(0, 16, 2, 48'({3'b111, 3'b110}));
        check("t3_err", err_w[0], 2'b01);
        check("t3_op_ok", op_ok[0], 0);
        check("t3_op", op_w[0], 0);
        check("t3_cand", cand_w[0], 8'h00);

        // Sample limit on the 4-sample instance
        do_start(1);
        run_list(1, 4, 4, 48'({3'b111, 3'b111, 3'b111, 3'b111}));
        check("t4_err", err_w[1], 2'b10);
        check("t4_cand", cand_w[1], 8'h43);
        check("t4_op_ok", op_ok[1], 0);
        check("t4_cnt", cnt_of(1), 4);

        // NAND pattern that ends in conflict unless resolved early
        do_start(0);
        run_list(0, 16, 4, 48'({3'b001, 3'b011, 3'b101, 3'b111}));
        check("t5_err", err_w[0], EARLY ? 0 : 1);
        check("t5_op", op_w[0], EARLY ? 3 : 0);
        check("t5_op_ok", op_ok[0], EARLY);
        check("t5_cnt", cnt_of(0), EARLY ? 3 : 4);

        // s_valid while idle is not accepted
        s_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", s_ready[0], 0);
            check("idle_cnt", cnt_of(0), m_cnt);
            check("idle_done", done[0], 0);
        end
        s_valid[0] = 1'b0;

        // Reset mid-collect: immediate abort, no done pulse
        do_start(0);
        run_list(0, 16, 2, 48'({3'b001, 3'b011}));
        idle(0, 1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        check("rst_no_done", done[0], 0);
        check("rst_stay_idle", busy[0], 0);

        // Randomized runs on both instances
        for (int r = 0; r < 60; r++) begin
            int u, maxs, tgt;
            bit a, b, y;
            u    = r % 2;
            maxs = (u == 0) ? 16 : 4;
            tgt  = $urandom_range(0, 7);
            do_start(u);
            for (int i = 0; i < maxs; i++) begin
                if (!m_done) begin
                    if ($urandom_range(0, 3) == 0) idle(u, $urandom_range(1, 2), 1'($urandom));
                    a = 1'($urandom);
                    b = 1'($urandom);
                    y = ($urandom_range(0, 4) == 0) ? 1'($urandom) : ref_y(tgt, a, b);
                    send(u, maxs, {a, b, y});
                end
            end
            check("rand_finished", m_done, 1);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mfu_op_decoder.md
Name: mfu_op_decoder

Overview:
- Inverse of the multi-function logic unit: observes serial (a, b, y) samples taken from a unit under observation and identifies which 3-bit function select produced them.
- Keeps an 8-bit candidate mask and drops each opcode that disagrees with an observed sample.
- Used in self-test and monitor paths next to the logic-unit datapath.

Parameters:
MAX_SAMPLES, 16, maximum samples accepted per run before aborting with an incomplete result (must be >=1).
CNT_W, $clog2(MAX_SAMPLES+1), derived width of the sample counter; do not override.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begins a run; honoured only in IDLE
s_valid  input  1  sample valid
s_ready  output  1  decoder accepts a sample this cycle
s_a  input  1  observed operand a
s_b  input  1  observed operand b
s_y  input  1  observed result y
busy  output  1  high in COLLECT and DONE
done  output  1  one-cycle pulse when the result is published
op  output  3  identified select code; valid when op_ok=1
op_ok  output  1  exactly one candidate remains
err  output  2  00 none, 01 conflict (no candidate left), 10 incomplete (sample limit reached)
cand  output  8  live candidate mask; bit k = opcode k
cnt  output  CNT_W  samples accepted in the current or last run

Behaviour:
- Opcode truth tables, with bit index {a,b} and table value y:
  - AND(0)=4'h8, OR(1)=4'hE, NOT-a(2)=4'h3, NAND(3)=4'h7
  - NOR(4)=4'h1, XOR(5)=4'h6, XNOR(6)=4'h9, ZERO(7)=4'h0
  - All eight tables are distinct.
- Reset values:
  - State IDLE.
  - s_ready=0, busy=0, done=0, op=0, op_ok=0, err=00.
  - cand=8'hFF, cnt=0, seen mask=0.
- IDLE:
  - start=1 moves the state to COLLECT next cycle.
  - On that same edge: cand<=8'hFF, seen<=0, cnt<=0, op_ok<=0, err<=00.
- COLLECT:
  - s_ready=1.
  - A handshake (s_valid&s_ready) on an edge does all of the following:
    - seen[{a,b}]<=1
    - cnt<=cnt+1
    - cand<=cand & match, where match[k]=(table_k[{a,b}]==s_y)
- Exit from COLLECT, evaluated on the new cand/seen/cnt at the same edge. Priority order:
  1. new cand==0 -> DONE, err=01, op_ok=0.
  2. new seen==4'hF -> DONE, op_ok=1, op=index of the single set cand bit.
  3. new cnt==MAX_SAMPLES -> DONE, err=10, op_ok=0.
  4. Otherwise stay in COLLECT.
- Repeated samples at the same index are legal. A contradicting repeat empties cand and gives err=01.
- DONE:
  - Lasts exactly one cycle, with done=1 and s_ready=0.
  - The state then returns to IDLE.
  - start is ignored in DONE and in COLLECT.
- Latency: done is high in the cycle immediately after the final handshake cycle.
- op, op_ok, err, cand and cnt hold their values after DONE until the next accepted start.
- op is 0 whenever op_ok=0.
- rst mid-run aborts immediately: all outputs take reset values and no done pulse is produced.

Optional Feature:
- Macro: MFU_DEC_EARLY_EN.
- When defined:
  - An extra exit condition sits between priorities 1 and 2: popcount(new cand)==1 -> DONE, op_ok=1, even if seen!=4'hF.
- When undefined:
  - Resolution waits for all four {a,b} indices to be seen.
  - No popcount logic is built.

Test Plan:
1. Reset, start, samples (0,0,1),(1,1,0),(0,1,1),(1,0,0) -> done in the cycle after the 4th handshake; op=3'b010, op_ok=1, err=00, cand=8'h04, cnt=4.
2. Samples (0,0,0),(1,1,0),(0,1,1):
   - EARLY defined -> done after the 3rd sample, op=3'b101, cnt=3.
   - EARLY undefined -> no done; a 4th sample (1,0,1) gives op=3'b101, cnt=4.
3. Samples (1,1,1),(1,1,0) -> done after the 2nd sample; err=01, op_ok=0, op=0, cand=8'h00.
4. MAX_SAMPLES=4, four samples of (1,1,1) -> done after the 4th; err=10, cand=8'h43, op_ok=0.
5. Samples (0,0,1),(0,1,1),(1,0,1),(1,1,1) -> EARLY undefined: err=01 after the 4th sample; EARLY defined: op=3'b011 after the 3rd sample.
6. rst asserted mid-COLLECT after 2 samples -> next cycle outputs are at reset values with no done. start pulsed while busy -> ignored and cnt is unaffected. s_valid with no start -> s_ready=0 and nothing is accepted.
